// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA state encoding and trigger address.
// Imported by the OAM DMA engine and the PPU top.
package ppu_pkg;

  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

endpackage

// File: rtl/ppu_oam_dma_if.sv
// OAM DMA bus bundle: CPU bus decode, DMA memory read path, OAM write port.
// master = bus/memory/PPU side, slave = DMA engine.
interface ppu_oam_dma_if #(
  parameter int OAM_AW = 8
);
  logic [15:0]       bus_addr;
  logic [7:0]        bus_din;
  logic              bus_wr;
  logic [7:0]        mem_din;
  logic              dma_hijack;
  logic [15:0]       dma_addr;
  logic              dma_rd;
  logic              oam_we;
  logic [OAM_AW-1:0] oam_waddr;
  logic [7:0]        oam_wdata;

  modport master (
    output bus_addr, bus_din, bus_wr, mem_din,
    input  dma_hijack, dma_addr, dma_rd,
    input  oam_we, oam_waddr, oam_wdata
  );

  modport slave (
    input  bus_addr, bus_din, bus_wr, mem_din,
    output dma_hijack, dma_addr, dma_rd,
    output oam_we, oam_waddr, oam_wdata
  );
endinterface

// File: rtl/ppu_oam_dma.sv
// Sprite OAM DMA: copies XFER_LEN bytes of CPU page into OAM, halting the CPU.
// Ports: cpu_clk, reset, odd_or_even, stall, oam_base, done, bus (slave).
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_ADDR,
  parameter int          XFER_LEN     = 256,
  parameter int          OAM_AW       = 8
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              odd_or_even,
  input  logic              stall,
  input  logic [OAM_AW-1:0] oam_base,
  output logic              done,
  ppu_oam_dma_if.slave      bus
);

  localparam int IW = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;

  dma_state_t        state, state_n;
  logic [7:0]        page;
  logic [OAM_AW-1:0] base;
  logic [IW-1:0]     idx;
  logic [15:0]       addr_q;
  logic              done_q;
  logic              trig, last, rd, we;
  logic [15:0]       rd_addr;

  assign trig    = (bus.bus_addr == TRIGGER_ADDR) && !bus.bus_wr;
  assign last    = (idx == IW'(XFER_LEN - 1));
  assign rd_addr = {page, 8'(idx)};

  always_comb begin
    state_n = state;
    rd      = 1'b0;
    we      = 1'b0;
    unique case (state)
      DMA_IDLE: if (trig) state_n = DMA_HALT;
      DMA_HALT:
        if (!stall)
          state_n = odd_or_even ? DMA_ALIGN : DMA_READ;
      DMA_ALIGN: if (!stall) state_n = DMA_READ;
      DMA_READ:
        if (!stall) begin
          rd      = 1'b1;
          state_n = DMA_WRITE;
        end
      DMA_WRITE:
        if (!stall) begin
          we      = 1'b1;
          state_n = last ? DMA_IDLE : DMA_READ;
        end
      default: state_n = DMA_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state  <= DMA_IDLE;
      page   <= '0;
      base   <= '0;
      idx    <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= we && last;
      if (state == DMA_IDLE && trig) begin
        page <= bus.bus_din;
        base <= oam_base;
        idx  <= '0;
      end
      if (we) idx <= idx + 1'b1;
      if (rd) addr_q <= rd_addr;
    end
  end

  // Address is live during a read and otherwise holds the last one issued.
  assign bus.dma_hijack = (state != DMA_IDLE);
  assign bus.dma_rd     = rd;
  assign bus.dma_addr   = rd ? rd_addr : addr_q;
  assign bus.oam_we     = we;
  assign bus.oam_waddr  = we ? base + OAM_AW'(idx) : '0;
  assign bus.oam_wdata  = we ? bus.mem_din : 8'h00;
  assign done           = done_q;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Scoreboard bench for ppu_oam_dma: 256-byte instance plus a 1-byte instance.
// Expected reads/writes are queued at stimulus time and checked by a monitor.
module tb_ppu_oam_dma;

  logic       cpu_clk = 1'b0;
  logic       reset = 1'b1;
  logic       odd_or_even = 1'b0;
  logic       stall0 = 1'b0;
  logic       stall1 = 1'b0;
  logic [7:0] oam_base = 8'h00;
  logic       done0, done1;
  logic [7:0] mem_q0 = 8'h00;
  logic [7:0] mem_q1 = 8'h00;

  int checks = 0;
  int failures = 0;
  int pending_done = 0;
  int wr_seen = 0;
  int w1_cnt = 0;
  int d1_cnt = 0;
  int w1_addr = 0;
  int w1_data = 0;

  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];

  always #5 cpu_clk = ~cpu_clk;

  ppu_oam_dma_if #(.OAM_AW(8)) ifc ();
  ppu_oam_dma_if #(.OAM_AW(8)) ifc1 ();

  ppu_oam_dma dut (
    .cpu_clk(cpu_clk), .reset(reset), .odd_or_even(odd_or_even),
    .stall(stall0), .oam_base(oam_base), .done(done0), .bus(ifc)
  );

  ppu_oam_dma #(.XFER_LEN(1)) dut1 (
    .cpu_clk(cpu_clk), .reset(reset), .odd_or_even(odd_or_even),
    .stall(stall1), .oam_base(oam_base), .done(done1), .bus(ifc1)
  );

  function automatic logic [7:0] f(input logic [15:0] a);
    logic [7:0] p;
    p = (a[15:8] == 8'h02) ? 8'h00 : a[15:8];
    return a[7:0] ^ 8'hA5 ^ p;
  endfunction

  // Memory: registered read, output held while dma_rd is low.
  always @(posedge cpu_clk) begin
    if (ifc.dma_rd) mem_q0 <= f(ifc.dma_addr);
    if (ifc1.dma_rd) mem_q1 <= f(ifc1.dma_addr);
  end
  assign ifc.mem_din  = mem_q0;
  assign ifc1.mem_din = mem_q1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  always @(negedge cpu_clk) begin
    logic [15:0] e;
    if (ifc.dma_rd) begin
      if (exp_rd.size() == 0) note_fail("rd_unexpected");
      else begin
        e = exp_rd.pop_front();
        chk("rd_addr", int'(ifc.dma_addr), int'(e));
      end
    end
    if (ifc.oam_we) begin
      wr_seen++;
      if (exp_wr.size() == 0) note_fail("wr_unexpected");
      else begin
        e = exp_wr.pop_front();
        chk("oam_waddr", int'(ifc.oam_waddr), int'(e[15:8]));
        chk("oam_wdata", int'(ifc.oam_wdata), int'(e[7:0]));
      end
    end
    if (done0) begin
      if (pending_done == 0) note_fail("done_unexpected");
      else pending_done--;
    end
    if (ifc1.oam_we) begin
      w1_cnt++;
      w1_addr = int'(ifc1.oam_waddr);
      w1_data = int'(ifc1.oam_wdata);
    end
    if (done1) d1_cnt++;
  end

  task automatic push_exp(input logic [7:0] pg, input logic [7:0] bs,
                          input int n);
    logic [15:0] a;
    logic [7:0]  wa;
    for (int i = 0; i < n; i++) begin
      a  = {pg, 8'(i)};
      wa = bs + 8'(i);
      exp_rd.push_back(a);
      exp_wr.push_back({wa, f(a)});
    end
    pending_done++;
  endtask

  task automatic drive_trig(input bit sel, input logic [7:0] pg);
    if (sel) begin
      ifc1.bus_addr = 16'h4014; ifc1.bus_din = pg; ifc1.bus_wr = 1'b0;
    end else begin
      ifc.bus_addr = 16'h4014; ifc.bus_din = pg; ifc.bus_wr = 1'b0;
    end
  endtask

  task automatic release_bus();
    ifc.bus_addr = 16'h0000; ifc.bus_din = 8'h00; ifc.bus_wr = 1'b1;
    ifc1.bus_addr = 16'h0000; ifc1.bus_din = 8'h00; ifc1.bus_wr = 1'b1;
  endtask

  task automatic trigger(input bit sel, input logic [7:0] pg);
    @(posedge cpu_clk); #1;
    drive_trig(sel, pg);
    @(posedge cpu_clk); #1;
    release_bus();
  endtask

  // Called at the start of the HALT cycle; counts hijack cycles.
  // mode 1: stall cycles 10-12 (READ) and 22-23 (WRITE).
  // mode 2: retrigger with page 07 at cycle 50.
  task automatic measure(input bit sel, input int mode, input bit chain,
                         input logic [7:0] chain_pg,
                         output int cnt, output int first_rd);
    int  n;
    logic h, r, d;
    n = 1; cnt = 0; first_rd = 0;
    forever begin
      stall0 = (mode == 1) && (n inside {10, 11, 12, 22, 23});
      if (mode == 2 && n == 50) drive_trig(sel, 8'h07);
      if (mode == 2 && n == 51) release_bus();
      @(negedge cpu_clk);
      h = sel ? ifc1.dma_hijack : ifc.dma_hijack;
      r = sel ? ifc1.dma_rd : ifc.dma_rd;
      d = sel ? done1 : done0;
      if (!h) begin
        chk("done_at_end", int'(d), 1);
        if (chain) drive_trig(sel, chain_pg);
        break;
      end
      cnt++;
      if (r && first_rd == 0) first_rd = n;
      if (n >= 1000) begin
        note_fail("hijack_timeout");
        break;
      end
      @(posedge cpu_clk); #1;
      n++;
    end
    stall0 = 1'b0;
  endtask

  initial begin
    int cnt, first_rd;
    bit hit;
    release_bus();
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("rst_hijack", int'(ifc.dma_hijack), 0);
    chk("rst_dma_addr", int'(ifc.dma_addr), 0);
    chk("rst_dma_rd", int'(ifc.dma_rd), 0);
    chk("rst_oam_we", int'(ifc.oam_we), 0);
    chk("rst_oam_waddr", int'(ifc.oam_waddr), 0);
    chk("rst_done", int'(done0), 0);
    @(posedge cpu_clk); #1;
    reset = 1'b0;

    // Even parity, base 0, page 02.
    push_exp(8'h02, 8'h00, 256);
    trigger(1'b0, 8'h02);
    measure(1'b0, 0, 1'b0, 8'h00, cnt, first_rd);
    chk("even_hijack", cnt, 513);
    chk("even_first_rd", first_rd, 2);

    // Odd parity adds the ALIGN cycle.
    odd_or_even = 1'b1;
    push_exp(8'h02, 8'h00, 256);
    trigger(1'b0, 8'h02);
    measure(1'b0, 0, 1'b0, 8'h00, cnt, first_rd);
    chk("odd_hijack", cnt, 514);
    chk("odd_first_rd", first_rd, 3);
    odd_or_even = 1'b0;

    // OAM wrap from base F0, page 03.
    oam_base = 8'hF0;
    push_exp(8'h03, 8'hF0, 256);
    trigger(1'b0, 8'h03);
    measure(1'b0, 0, 1'b0, 8'h00, cnt, first_rd);
    chk("wrap_hijack", cnt, 513);
    oam_base = 8'h00;

    // Stalls: 3 in READ, 2 in WRITE.
    push_exp(8'h02, 8'h00, 256);
    trigger(1'b0, 8'h02);
    measure(1'b0, 1, 1'b0, 8'h00, cnt, first_rd);
    chk("stall_hijack", cnt, 518);

    // Ignored retrigger, then back-to-back trigger in the done cycle.
    push_exp(8'h02, 8'h00, 256);
    push_exp(8'h04, 8'h00, 256);
    trigger(1'b0, 8'h02);
    measure(1'b0, 2, 1'b1, 8'h04, cnt, first_rd);
    chk("retrig_hijack", cnt, 513);
    @(posedge cpu_clk); #1;
    release_bus();
    measure(1'b0, 0, 1'b0, 8'h00, cnt, first_rd);
    chk("b2b_hijack", cnt, 513);

    // Reset after 100 bytes.
    oam_base = 8'h10;
    push_exp(8'h02, 8'h10, 256);
    wr_seen = 0;
    trigger(1'b0, 8'h02);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge cpu_clk); #1;
      if (wr_seen >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_byte100", int'(hit), 1);
    reset = 1'b1;
    @(posedge cpu_clk); #1;
    reset = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    pending_done = 0;
    @(negedge cpu_clk);
    chk("mid_rst_hijack", int'(ifc.dma_hijack), 0);
    chk("mid_rst_oam_we", int'(ifc.oam_we), 0);
    chk("mid_rst_done", int'(done0), 0);
    repeat (5) @(posedge cpu_clk);
    #1;
    oam_base = 8'h00;
    push_exp(8'h02, 8'h00, 256);
    trigger(1'b0, 8'h02);
    measure(1'b0, 0, 1'b0, 8'h00, cnt, first_rd);
    chk("post_rst_hijack", cnt, 513);

    // XFER_LEN = 1 instance, even then odd.
    oam_base = 8'h33;
    w1_cnt = 0; d1_cnt = 0;
    trigger(1'b1, 8'h05);
    measure(1'b1, 0, 1'b0, 8'h00, cnt, first_rd);
    chk("len1_even_hijack", cnt, 3);
    @(negedge cpu_clk);
    chk("len1_writes", w1_cnt, 1);
    chk("len1_waddr", w1_addr, 8'h33);
    chk("len1_wdata", w1_data, int'(f(16'h0500)));
    chk("len1_done", d1_cnt, 1);
    odd_or_even = 1'b1;
    w1_cnt = 0; d1_cnt = 0;
    trigger(1'b1, 8'h06);
    measure(1'b1, 0, 1'b0, 8'h00, cnt, first_rd);
    chk("len1_odd_hijack", cnt, 4);
    @(negedge cpu_clk);
    chk("len1_odd_writes", w1_cnt, 1);
    chk("len1_odd_wdata", w1_data, int'(f(16'h0600)));
    odd_or_even = 1'b0;

    repeat (3) @(posedge cpu_clk);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("done_pending", pending_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
